pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_slice.sv | 14 +
 rtl/pipe_adder.sv | 138 +++++++++++++
 tb/tb_pipe_adder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and result flag bundle for pipe_adder.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   flags_t                : {zero, carry, overflow, negative}
package adder_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_STAGES = 2;
    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: W-bit ripple slice of the pipelined adder.
//   a, b : slice operands   cin : carry in
//   s    : slice sum        cout: carry out
module adder_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-pipelined add/sub with valid/ready handshake.
//   clk, rst (async, active-high)
//   in_valid/in_ready, sub, sat, a, b : operation input
//   out_valid/out_ready, sum, zero, carry, overflow, negative : result output
//   Macro PIPE_ADDER_SAT_EN enables saturation of overflowing ops when sat=1.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             sat,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);
    localparam int S = WIDTH / STAGES;
    localparam int L = STAGES - 1;
    logic adv;
    flags_t fl;
    logic [WIDTH-1:0] raw;
    // One enable for the whole pipe: bubbles are kept in place during a stall.
    assign adv = out_ready | ~out_valid;
    assign in_ready = adv;
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g
            // IW: operand bits still unresolved on entry; RW: result bits known after this stage
            localparam int IW = WIDTH - k * S;
            localparam int RW = (k + 1) * S;
            logic [IW-1:0] ai, bi;
            logic ci, vi, co, c, v;
            logic [S-1:0] s;
            logic [RW-1:0] rn, r;
`ifdef PIPE_ADDER_SAT_EN
            logic ti, t;
`endif
            if (k == 0) begin : g_in
                assign ai = a;
                assign bi = b ^ {WIDTH{sub}};
                assign ci = sub;
                assign vi = in_valid;
                assign rn = s;
`ifdef PIPE_ADDER_SAT_EN
                assign ti = sat;
`endif
            end else begin : g_nx
                assign ai = g[k-1].d.oa;
                assign bi = g[k-1].d.ob;
                assign ci = g[k-1].c;
                assign vi = g[k-1].v;
                assign rn = {s, g[k-1].r};
`ifdef PIPE_ADDER_SAT_EN
                assign ti = g[k-1].t;
`endif
            end
            adder_slice #(.W(S)) u_slice (
                .a(ai[S-1:0]),
                .b(bi[S-1:0]),
                .cin(ci),
                .s(s),
                .cout(co)
            );
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v <= 1'b0;
                    c <= 1'b0;
                    r <= '0;
`ifdef PIPE_ADDER_SAT_EN
                    t <= 1'b0;
`endif
                end else if (adv) begin
                    v <= vi;
                    c <= co;
                    r <= rn;
`ifdef PIPE_ADDER_SAT_EN
                    t <= ti;
`endif
                end
            end
            if (k < L) begin : d
                logic [IW-S-1:0] oa, ob;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        oa <= '0;
                        ob <= '0;
                    end else if (adv) begin
                        oa <= ai[IW-1:S];
                        ob <= bi[IW-1:S];
                    end
                end
            end else begin : e
                // Top slice: overflow is decided here from the operand and result sign bits.
                logic o;
`ifdef PIPE_ADDER_SAT_EN
                logic m;
`endif
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        o <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
                        m <= 1'b0;
`endif
                    end else if (adv) begin
                        o <= (~ai[S-1] & ~bi[S-1] & s[S-1]) | (ai[S-1] & bi[S-1] & ~s[S-1]);
`ifdef PIPE_ADDER_SAT_EN
                        m <= ai[S-1];
`endif
                    end
                end
            end
        end
    endgenerate
    assign raw = g[L].r;
    assign out_valid = g[L].v;
`ifdef PIPE_ADDER_SAT_EN
    // On overflow the sign of a gives the true direction: negative a -> min, else max.
    assign sum = (g[L].t & g[L].e.o) ? {g[L].e.m, {(WIDTH-1){~g[L].e.m}}} : raw;
`else
    logic sat_unused;
    assign sat_unused = sat;
    assign sum = raw;
`endif
    assign fl = '{zero: out_valid & ~|sum, carry: out_valid & g[L].c,
                  overflow: out_valid & g[L].e.o, negative: out_valid & sum[WIDTH-1]};
    assign {zero, carry, overflow, negative} = fl;
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: self-checking bench for pipe_adder (directed vectors + reference model).
module tb_pipe_adder;
    localparam int W = 32;
    localparam int N = 2;
`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, sub, sat, out_valid, out_ready;
    logic zero, carry, overflow, negative;
    logic [W-1:0] a, b, sum;
    logic [3:0] fl;
    int checks = 0, failures = 0, cyc = 0, stalls = 0;
    bit done = 0;
    typedef struct {
        logic [W-1:0] s;
        logic [3:0] f;
        int acc;
        int st;
        bit seen;
    } exp_t;
    exp_t q[$];
    logic [W-1:0] got[$];

    pipe_adder #(.WIDTH(W), .STAGES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .sat(sat), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .zero(zero), .carry(carry), .overflow(overflow), .negative(negative)
    );

    assign fl = {zero, carry, overflow, negative};
    always #5 clk = ~clk;

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [W-1:0] x, y, input logic sb, st);
        exp_t e;
        longint sx, sy, ux, uy, r, ur, mx, mn;
        logic c, o;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        mx = (longint'(1) << (W - 1)) - 1;
        mn = -(longint'(1) << (W - 1));
        r = sb ? sx - sy : sx + sy;
        ur = sb ? ux - uy : ux + uy;
        c = sb ? (ux >= uy) : (ur >= (longint'(1) << W));
        o = (r > mx) || (r < mn);
        e.s = W'(r);
        if (SAT_EN && st && o) e.s = (r > 0) ? W'(mx) : W'(mn);
        e.f = {e.s == '0, c, o, e.s[W-1]};
        e.acc = 0;
        e.st = 0;
        e.seen = 0;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin : mon
        exp_t e;
        if (rst) q.delete();
        else begin
            if (out_valid && out_ready && q.size() > 0) begin
                got.push_back(sum);
                void'(q.pop_front());
            end
            if (out_valid && !out_ready) stalls++;
            if (in_valid && in_ready) begin
                e = model(a, b, sub, sat);
                e.acc = cyc;
                e.st = stalls;
                q.push_back(e);
            end
            cyc++;
        end
    end

    logic [W-1:0] h_sum;
    logic [3:0] h_f;
    bit held = 0;
    always @(negedge clk) begin
        if (held) begin
            checks++;
            if (!out_valid || sum !== h_sum || fl !== h_f) begin
                failures++;
                $display("FAIL hold: valid=%0b sum=0x%h flags=%b, required valid=1 sum=0x%h flags=%b",
                         out_valid, sum, fl, h_sum, h_f);
            end
        end
        if (!rst && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL order: result 0x%h present, required none outstanding", sum);
            end else begin
                if (sum !== q[0].s || fl !== q[0].f) begin
                    failures++;
                    $display("FAIL result: sum=0x%h flags=%b, required sum=0x%h flags=%b",
                             sum, fl, q[0].s, q[0].f);
                end
                if (!q[0].seen) begin
                    q[0].seen = 1;
                    if (q[0].st == stalls) begin
                        checks++;
                        if (cyc - q[0].acc != N) begin
                            failures++;
                            $display("FAIL latency: %0d cycles, required %0d", cyc - q[0].acc, N);
                        end
                    end
                end
            end
        end
        held = !rst && out_valid && !out_ready;
        h_sum = sum;
        h_f = fl;
    end

    task automatic chk(input string name, input logic [W-1:0] g, e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s: got 0x%h required 0x%h", name, g, e);
        end
    endtask

    task automatic push_op(input logic [W-1:0] x, y, input logic sb, st);
        bit acc = 0;
        a = x;
        b = y;
        sub = sb;
        sat = st;
        in_valid = 1;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=0 for 40 cycles, required 1");
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] x, y, input logic sb, st,
                         input logic [W-1:0] es, input logic [3:0] ef);
        push_op(x, y, sb, st);
        for (int i = 1; i < N; i++) begin
            chk({name, "_early"}, W'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        chk({name, "_valid"}, W'(out_valid), 1);
        chk({name, "_sum"}, sum, es);
        chk({name, "_flags"}, W'(fl), W'(ef));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            4: return W'(32'h0000_FFFF);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        in_valid = 0;
        out_ready = 1;
        sub = 0;
        sat = 0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", W'(out_valid), 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", W'(fl), 0);
        rst = 0;
        @(posedge clk);
        #1;
        chk("init_ready", W'(in_ready), 1);

        do_op("max_plus_1", 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 4'b1100);
        do_op("slice_carry", 32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 4'b0000);
        do_op("sub_equal", 32'h5, 32'h5, 1, 0, 32'h0, 4'b1100);
        do_op("sub_borrow", 32'h3, 32'h5, 1, 0, 32'hFFFF_FFFE, 4'b0001);
        do_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 4'b0011);
        do_op("ovf_pos_sat", 32'h7FFF_FFFF, 32'h1, 0, 1,
              SAT_EN ? 32'h7FFF_FFFF : 32'h8000_0000, SAT_EN ? 4'b0010 : 4'b0011);
        do_op("ovf_neg", 32'h8000_0000, 32'h1, 1, 0, 32'h7FFF_FFFF, 4'b0110);

        got.delete();
        fork
            begin
                push_op(32'd1, 32'd2, 0, 0);
                push_op(32'd10, 32'd20, 0, 0);
                push_op(32'h0000_FFFF, 32'd1, 0, 0);
                push_op(32'd9, 32'd4, 1, 0);
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 0;
                @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    chk("stall_in_ready", W'(in_ready), 0);
                    chk("stall_valid", W'(out_valid), 1);
                    chk("stall_sum", sum, 32'd3);
                end
                out_ready = 1;
            end
        join
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("stream_drain", W'(q.size()), 0);
        chk("stream_count", W'(got.size()), 4);
        if (got.size() == 4) begin
            chk("stream_0", got[0], 32'd3);
            chk("stream_1", got[1], 32'd30);
            chk("stream_2", got[2], 32'h0001_0000);
            chk("stream_3", got[3], 32'd5);
        end

        push_op(32'h11, 32'h22, 0, 0);
        push_op(32'h33, 32'h44, 0, 0);
        rst = 1;
        #1;
        chk("midrst_valid", W'(out_valid), 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_flags", W'(fl), 0);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", W'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            chk("no_ghost", W'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        do_op("post_rst", 32'h1234, 32'h1111, 0, 0, 32'h2345, 4'b0000);

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    push_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("random_drain", W'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
